// File: rtl/rio_pkg.sv
// Shared SRIO logical-layer constants, header layout and target FSM states.
// No logic: type and constant definitions only.
// Backpressure: n/a.
package rio_pkg;

    localparam logic [3:0]  FTYPE_DOORB   = 4'hA;
    localparam logic [3:0]  FTYPE_NWR     = 4'h5;
    localparam logic [3:0]  TTYPE_NWR     = 4'h4;

    localparam logic [15:0] OWN_ID        = 16'h00F0;
    localparam logic [15:0] DB_READY_INFO = 16'h0100;
    localparam logic [15:0] DB_BUSY_INFO  = 16'h01FF;

    localparam int TID_LSB   = 56;
    localparam int FTYPE_LSB = 52;
    localparam int TTYPE_LSB = 48;
    localparam int PRIO_LSB  = 45;
    localparam int SIZE_LSB  = 36;
    localparam int INFO_LSB  = 16;
    localparam int ADDR_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DB_RESP,
        ST_NWR_DATA,
        ST_DISCARD
    } state_t;

    typedef struct packed {
        logic [7:0]  tid;
        logic [3:0]  ftype;
        logic [3:0]  ttype;
        logic [1:0]  prio;
        logic [7:0]  size;
        logic [33:0] addr;
        logic [15:0] info;
    } hdr_t;

    // Response priority is one above the request, clamped at the top level.
    function automatic logic [1:0] prio_inc(input logic [1:0] p);
        return (p == 2'h3) ? 2'h3 : p + 2'h1;
    endfunction

endpackage

// File: rtl/rio_hdr_decode.sv
// Splits a treq header beat into its logical-layer fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the fields with its own handshake.
module rio_hdr_decode
    import rio_pkg::*;
(
    input  logic [63:0] tdata,
    output hdr_t        hdr
);

    always_comb begin
        hdr       = '0;
        hdr.tid   = tdata[TID_LSB   +: 8];
        hdr.ftype = tdata[FTYPE_LSB +: 4];
        hdr.ttype = tdata[TTYPE_LSB +: 4];
        hdr.prio  = tdata[PRIO_LSB  +: 2];
        hdr.size  = tdata[SIZE_LSB  +: 8];
        hdr.addr  = tdata[ADDR_LSB  +: 34];
        hdr.info  = tdata[INFO_LSB  +: 16];
    end

    // Reserved header bits carry no meaning for this target.
    wire unused_rsvd = ^{tdata[47], tdata[44], tdata[35:34]};

endmodule

// File: rtl/db_nwr_target.sv
// SRIO target: answers doorbells with ready/busy info, unpacks NWRITE into an addressed user write stream.
// Latency: doorbell response 1 cycle after header; NWRITE data 0 cycles (pass-through); done/len_err pulses 1 cycle after last beat.
// Backpressure: treq stalls on tresp_tready_in in DB_RESP and follows user_wr_ready_in in NWR_DATA. Optional NWR_LEN_CHECK_EN adds the beat-count check.
module db_nwr_target
    import rio_pkg::*;
(
    input  logic        log_clk,
    input  logic        log_rst,

    input  logic        treq_tvalid_in,
    output logic        treq_tready_o,
    input  logic        treq_tlast_in,
    input  logic [63:0] treq_tdata_in,
    input  logic [7:0]  treq_tkeep_in,
    input  logic [31:0] treq_tuser_in,

    output logic        tresp_tvalid_o,
    input  logic        tresp_tready_in,
    output logic        tresp_tlast_o,
    output logic [63:0] tresp_tdata_o,
    output logic [7:0]  tresp_tkeep_o,
    output logic [31:0] tresp_tuser_o,

    input  logic        user_busy_in,
    output logic        user_wr_valid_o,
    input  logic        user_wr_ready_in,
    output logic        user_wr_last_o,
    output logic [33:0] user_wr_addr_o,
    output logic [63:0] user_wr_data_o,
    output logic [7:0]  user_wr_keep_o,

    output logic        nwr_done_o,
    output logic        unsup_pkt_o,
    output logic        nwr_len_err_o
);

    state_t      state, state_nxt;
    hdr_t        hdr;
    logic        unsup_nxt;
    logic [33:0] wr_addr;
    logic [63:0] tresp_dat_r;
    logic [31:0] tresp_usr_r;
    logic        nwr_done_r;
    logic        unsup_r;

    rio_hdr_decode u_hdr_decode (
        .tdata (treq_tdata_in),
        .hdr   (hdr)
    );

    // A doorbell must be a single beat; an NWRITE header must be followed by payload.
    wire is_db    = (hdr.ftype == FTYPE_DOORB) && treq_tlast_in;
    wire is_nwr   = (hdr.ftype == FTYPE_NWR) && (hdr.ttype == TTYPE_NWR) && !treq_tlast_in;
    wire hdr_acc  = (state == ST_IDLE) && treq_tvalid_in;
    wire nwr_beat = (state == ST_NWR_DATA) && treq_tvalid_in && user_wr_ready_in;

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        treq_tready_o = 1'b0;
        unsup_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                treq_tready_o = 1'b1;
                if (treq_tvalid_in) begin
                    if (is_db) begin
                        state_nxt = ST_DB_RESP;
                    end else if (is_nwr) begin
                        state_nxt = ST_NWR_DATA;
                    end else begin
                        unsup_nxt = 1'b1;
                        if (!treq_tlast_in) state_nxt = ST_DISCARD;
                    end
                end
            end
            ST_DB_RESP: begin
                if (tresp_tready_in) state_nxt = ST_IDLE;
            end
            ST_NWR_DATA: begin
                treq_tready_o = user_wr_ready_in;
                if (nwr_beat && treq_tlast_in) state_nxt = ST_IDLE;
            end
            ST_DISCARD: begin
                treq_tready_o = 1'b1;
                if (treq_tvalid_in && treq_tlast_in) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            tresp_dat_r <= '0;
            tresp_usr_r <= '0;
            wr_addr     <= '0;
            nwr_done_r  <= 1'b0;
            unsup_r     <= 1'b0;
        end else begin
            nwr_done_r <= nwr_beat && treq_tlast_in;
            unsup_r    <= unsup_nxt;
            if (hdr_acc && is_db) begin
                tresp_dat_r <= {hdr.tid, FTYPE_DOORB, 4'h0, 1'b0, prio_inc(hdr.prio), 1'b0, 12'h0,
                                user_busy_in ? DB_BUSY_INFO : DB_READY_INFO, 16'h0};
                tresp_usr_r <= {OWN_ID, treq_tuser_in[31:16]};
            end
            if (hdr_acc && is_nwr) wr_addr <= hdr.addr;
            else if (nwr_beat)     wr_addr <= wr_addr + 34'd8;
        end
    end

    assign tresp_tvalid_o  = (state == ST_DB_RESP);
    assign tresp_tlast_o   = tresp_tvalid_o;
    assign tresp_tkeep_o   = tresp_tvalid_o ? 8'hFF : 8'h00;
    assign tresp_tdata_o   = tresp_dat_r;
    assign tresp_tuser_o   = tresp_usr_r;

    assign user_wr_valid_o = (state == ST_NWR_DATA) && treq_tvalid_in;
    assign user_wr_last_o  = (state == ST_NWR_DATA) && treq_tlast_in;
    assign user_wr_addr_o  = wr_addr;
    assign user_wr_data_o  = treq_tdata_in;
    assign user_wr_keep_o  = treq_tkeep_in;

    assign nwr_done_o      = nwr_done_r;
    assign unsup_pkt_o     = unsup_r;

`ifdef NWR_LEN_CHECK_EN
    logic [4:0] exp_last_idx;
    logic [5:0] beat_cnt;
    logic       len_err_r;

    // Payload is whole 8-byte beats, so size[7:3] is the index of the final beat.
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            exp_last_idx <= '0;
            beat_cnt     <= '0;
            len_err_r    <= 1'b0;
        end else begin
            len_err_r <= 1'b0;
            if (hdr_acc && is_nwr) begin
                exp_last_idx <= hdr.size[7:3];
                beat_cnt     <= '0;
            end else if (nwr_beat) begin
                beat_cnt <= beat_cnt + 6'd1;
                if (treq_tlast_in && (beat_cnt != {1'b0, exp_last_idx})) len_err_r <= 1'b1;
            end
        end
    end

    assign nwr_len_err_o = len_err_r;
`else
    assign nwr_len_err_o = 1'b0;
`endif

    wire unused_ok = ^{treq_tuser_in[15:0], hdr.size, hdr.info};

endmodule
